sram_req_adapter: RTL

Upstream front-end for the single-port SRAM macro model. It accepts byte-addressed valid/ready memory requests with byte enables, range-checks them against the SRAM window, and issues them to the SRAM as word-indexed req/write/addr/wdata/wmask. It captures the SRAM's 1-cycle read data into a 2-entry in-order response buffer with valid/ready backpressure. Writes and range errors also produce responses.

---
 rtl/sram_req_adapter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sram_req_adapter.sv
// Valid/ready front-end for a single-port SRAM: range-checks byte-addressed requests,
// issues word-indexed accesses and returns in-order responses through a 2-entry buffer.
module sram_req_adapter #(
    parameter int                   Width      = 32,
    parameter int                   Depth      = 1 << 15,
    parameter int                   AddrWidth  = 32,
    parameter logic [AddrWidth-1:0] BaseAddr   = 32'h8000_0000,
    localparam int                  WidthBytes = Width / 8,
    localparam int                  Aw         = $clog2(Depth),
    localparam int                  Ob         = $clog2(WidthBytes)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [AddrWidth-1:0]  req_addr_i,
    input  logic [Width-1:0]      req_wdata_i,
    input  logic [WidthBytes-1:0] req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [Width-1:0]      rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  sram_req_o,
    output logic                  sram_write_o,
    output logic [Aw-1:0]         sram_addr_o,
    output logic [Width-1:0]      sram_wdata_o,
    output logic [Width-1:0]      sram_wmask_o,
    input  logic [Width-1:0]      sram_rdata_i
);

    localparam logic [AddrWidth:0] Span = (AddrWidth + 1)'(Depth * WidthBytes);

    typedef struct packed {
        logic             err;
        logic [Width-1:0] rdata;
    } rsp_t;

    logic               acc;
    logic               in_range;
    logic [AddrWidth:0] off;

    logic s1_valid;
    logic s1_write;
    logic s1_err;

    rsp_t       fifo_mem [2];
    rsp_t       push_entry;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic [2:0] occ;

    // One extra bit keeps addresses below BaseAddr from wrapping into the window.
    assign off      = {1'b0, req_addr_i} - {1'b0, BaseAddr};
    assign in_range = (req_addr_i >= BaseAddr) && (off < Span);
    assign acc      = req_valid_i & req_ready_o;

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        sram_req_o   = 1'b0;
        sram_write_o = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wmask_o = '0;
        if (acc && in_range) begin
            sram_req_o   = 1'b1;
            sram_write_o = req_write_i;
            sram_addr_o  = off[Ob +: Aw];
            sram_wdata_o = req_wdata_i;
            if (req_write_i) begin
                for (int i = 0; i < Width; i++) begin
                    sram_wmask_o[i] = req_be_i[i / 8];
                end
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_write <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= acc;
            s1_write <= req_write_i;
            s1_err   <= ~in_range;
        end
    end

    // Read data is only meaningful for in-range reads; everything else answers zero.
    assign push             = s1_valid;
    assign push_entry.err   = s1_err;
    assign push_entry.rdata = (s1_write || s1_err) ? '0 : sram_rdata_i;

    assign rsp_valid_o = (count != 2'd0);
    assign pop         = rsp_valid_o & rsp_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // NOTE: payload storage is not reset; outputs are gated by rsp_valid_o so stale entries never show.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

    assign rsp_rdata_o = rsp_valid_o ? fifo_mem[rd_ptr].rdata : '0;
    assign rsp_err_o   = rsp_valid_o ? fifo_mem[rd_ptr].err   : 1'b0;

    // Credit counts buffered plus in-flight responses, freeing the slot being popped now.
    assign occ         = {1'b0, count} + {2'b00, s1_valid} - {2'b00, pop};
    assign req_ready_o = (occ < 3'd2);

endmodule
